// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station and the CDB arbiter:
// entry states, sizes, CDB field positions and small CDB decode helpers.
package rs_pkg;

    localparam int NUM_ENTRIES = 4;
    localparam int SLOT_W      = 2;
    localparam int TAG_W       = SLOT_W + 1;
    localparam int CDB_W       = 16;

    localparam int CDB_DEST_HI = 15;
    localparam int CDB_DEST_LO = 13;
    localparam int CDB_SLOT_HI = 12;
    localparam int CDB_SLOT_LO = 11;
    localparam int CDB_ULA_BIT = 10;
    localparam int CDB_DATA_HI = 9;
    localparam int CDB_DATA_LO = 0;

    localparam logic [CDB_W-1:0] CDB_IDLE = '0;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } entry_state_t;

    // Only ALU results with a real destination count; ld/sd traffic is ignored.
    function automatic logic cdb_is_result(input logic [CDB_W-1:0] cdb);
        return cdb[CDB_ULA_BIT] && (cdb[CDB_DEST_HI:CDB_DEST_LO] != '0);
    endfunction

    function automatic logic tag_hit(input logic             pend,
                                     input logic [SLOT_W-1:0] tag_slot,
                                     input logic [CDB_W-1:0]  cdb);
        return pend && cdb_is_result(cdb) &&
               (tag_slot == cdb[CDB_SLOT_HI:CDB_SLOT_LO]);
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and ALU dispatch signals of the reservation station.
interface reservation_station_if #(
    parameter int DATA_W = 10
);
    import rs_pkg::*;

    // Issue handshake: a request is taken on a rising edge where
    // issue_valid && issue_ready; issue_ready and issue_slot depend only on
    // registered state, so the requester may look at them before raising valid.
    logic                    issue_valid;
    logic                    issue_ready;
    logic [SLOT_W-1:0]       issue_slot;
    logic                    issue_op;
    logic [2:0]              issue_dest;
    logic [DATA_W-1:0]       issue_vj;
    logic [DATA_W-1:0]       issue_vk;
    logic [TAG_W-1:0]        issue_qj;
    logic [TAG_W-1:0]        issue_qk;

    logic [CDB_W-1:0]        cdb;

    logic                    alu_valid;
    logic                    alu_op;
    logic [DATA_W-1:0]       alu_a;
    logic [DATA_W-1:0]       alu_b;
    logic [2:0]              alu_dest;
    logic [SLOT_W-1:0]       alu_slot;

    logic [NUM_ENTRIES-1:0]  busy_mask;

    modport master (
        output issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
               issue_qj, issue_qk, cdb,
        input  issue_ready, issue_slot, alu_valid, alu_op, alu_a, alu_b,
               alu_dest, alu_slot, busy_mask
    );

    modport slave (
        input  issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
               issue_qj, issue_qk, cdb,
        output issue_ready, issue_slot, alu_valid, alu_op, alu_a, alu_b,
               alu_dest, alu_slot, busy_mask
    );

endinterface

// File: rtl/rs_find_first.sv
// Lowest-index picker: one-hot grant, encoded index and an any-request flag.
module rs_find_first #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Four-entry reservation station: tag wakeup from the CDB, same-cycle
// forwarding on issue, one lowest-index dispatch per cycle to the ALU.
module reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_W      = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    reservation_station_if.slave     rs,
    output logic [2*NUM_ENTRIES-1:0] state_dbg
);
    import rs_pkg::*;

    typedef struct packed {
        logic              op;
        logic [2:0]        dest;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic              qj_p;
        logic [SLOT_W-1:0] qj_s;
        logic              qk_p;
        logic [SLOT_W-1:0] qk_s;
    } entry_t;

    entry_state_t            state_q [NUM_ENTRIES];
    entry_state_t            state_d [NUM_ENTRIES];
    entry_t                  ent_q   [NUM_ENTRIES];
    entry_t                  ent_d   [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0]  free_req, free_oh;
    logic [NUM_ENTRIES-1:0]  ready_req, ready_oh;
    logic [SLOT_W-1:0]       free_idx, ready_idx;
    logic                    free_any, ready_any;
    logic                    do_issue;
    logic                    bcast;
    logic [SLOT_W-1:0]       cdb_slot;
    logic [DATA_W-1:0]       cdb_data;

    logic                    alu_valid_q, alu_op_q;
    logic [DATA_W-1:0]       alu_a_q, alu_b_q;
    logic [2:0]              alu_dest_q;
    logic [SLOT_W-1:0]       alu_slot_q;

    rs_find_first #(.N(NUM_ENTRIES), .IDX_W(SLOT_W)) u_free_pick (
        .req   (free_req),
        .grant (free_oh),
        .idx   (free_idx),
        .any   (free_any)
    );

    rs_find_first #(.N(NUM_ENTRIES), .IDX_W(SLOT_W)) u_ready_pick (
        .req   (ready_req),
        .grant (ready_oh),
        .idx   (ready_idx),
        .any   (ready_any)
    );

    assign do_issue = rs.issue_valid && free_any;
    assign bcast    = cdb_is_result(rs.cdb);
    assign cdb_slot = rs.cdb[CDB_SLOT_HI:CDB_SLOT_LO];
    assign cdb_data = DATA_W'(rs.cdb[CDB_DATA_HI:CDB_DATA_LO]);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                ent_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                ent_q[i]   <= ent_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            ent_d[i]   = ent_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (do_issue && free_oh[i]) begin
                        ent_d[i].op   = rs.issue_op;
                        ent_d[i].dest = rs.issue_dest;
                        ent_d[i].vj   = rs.issue_vj;
                        ent_d[i].vk   = rs.issue_vk;
                        ent_d[i].qj_p = rs.issue_qj[TAG_W-1];
                        ent_d[i].qj_s = rs.issue_qj[SLOT_W-1:0];
                        ent_d[i].qk_p = rs.issue_qk[TAG_W-1];
                        ent_d[i].qk_s = rs.issue_qk[SLOT_W-1:0];
                        state_d[i]    = ST_WAIT;
                    end
                end
                ST_READY: begin
                    if (ready_oh[i]) state_d[i] = ST_EXEC;
                end
                ST_EXEC: begin
                    if (bcast && (cdb_slot == SLOT_W'(i))) state_d[i] = ST_FREE;
                end
                default: ;
            endcase

            // Fresh issues pass through the same capture as waiting entries,
            // which gives same-cycle forwarding and direct entry into READY.
            if (state_d[i] == ST_WAIT) begin
                if (tag_hit(ent_d[i].qj_p, ent_d[i].qj_s, rs.cdb)) begin
                    ent_d[i].vj   = cdb_data;
                    ent_d[i].qj_p = 1'b0;
                end
                if (tag_hit(ent_d[i].qk_p, ent_d[i].qk_s, rs.cdb)) begin
                    ent_d[i].vk   = cdb_data;
                    ent_d[i].qk_p = 1'b0;
                end
                if (!ent_d[i].qj_p && !ent_d[i].qk_p) state_d[i] = ST_READY;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        free_req  = '0;
        ready_req = '0;
        state_dbg = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_req[i]          = (state_q[i] == ST_FREE);
            ready_req[i]         = (state_q[i] == ST_READY);
            state_dbg[2*i +: 2]  = state_q[i];
        end
    end

    assign rs.issue_ready = free_any;
    assign rs.issue_slot  = free_idx;
    assign rs.busy_mask   = ~free_req;

    // Dispatch register: data holds when nothing is ready
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_valid_q <= 1'b0;
            alu_op_q    <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_dest_q  <= '0;
            alu_slot_q  <= '0;
        end else begin
            alu_valid_q <= ready_any;
            if (ready_any) begin
                alu_op_q   <= ent_q[ready_idx].op;
                alu_a_q    <= ent_q[ready_idx].vj;
                alu_b_q    <= ent_q[ready_idx].vk;
                alu_dest_q <= ent_q[ready_idx].dest;
                alu_slot_q <= ready_idx;
            end
        end
    end

    assign rs.alu_valid = alu_valid_q;
    assign rs.alu_op    = alu_op_q;
    assign rs.alu_a     = alu_a_q;
    assign rs.alu_b     = alu_b_q;
    assign rs.alu_dest  = alu_dest_q;
    assign rs.alu_slot  = alu_slot_q;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus a randomized run
// checked against a slot-level behavioural model and a dispatch queue.
module tb_reservation_station;
    import rs_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] state_dbg;

    reservation_station_if #(.DATA_W(10)) rs();

    reservation_station #(.NUM_ENTRIES(4), .DATA_W(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .rs        (rs),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected dispatches: {op, a, b, dest, slot}
    logic [25:0] exp_q[$];

    typedef struct {
        bit         used;
        bit         sent;
        bit         wa;
        bit         wb;
        logic [1:0] ta;
        logic [1:0] tb;
        logic [9:0] a;
        logic [9:0] b;
        logic       op;
        logic [2:0] dest;
    } m_ent_t;

    m_ent_t     m [4];
    logic       m_alu_valid, m_alu_op;
    logic [9:0] m_alu_a, m_alu_b;
    logic [2:0] m_alu_dest;
    logic [1:0] m_alu_slot;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = '{default: 0};
        m_alu_valid = 0; m_alu_op = 0; m_alu_a = 0; m_alu_b = 0;
        m_alu_dest = 0;  m_alu_slot = 0;
        exp_q.delete();
    endtask

    // One clock edge of the slot model, using the inputs currently driven.
    task automatic model_step();
        int         fs, rd;
        bit         bc;
        logic [1:0] cs;
        logic [9:0] cd;
        m_ent_t     nw;
        fs = -1; rd = -1;
        for (int i = 0; i < 4; i++) begin
            if (!m[i].used && fs < 0) fs = i;
            if (m[i].used && !m[i].sent && !m[i].wa && !m[i].wb && rd < 0) rd = i;
        end
        bc = rs.cdb[10] && (rs.cdb[15:13] != 3'd0);
        cs = rs.cdb[12:11];
        cd = rs.cdb[9:0];
        for (int i = 0; i < 4; i++) begin
            if (bc && m[i].used) begin
                if (m[i].sent && cs == 2'(i)) m[i].used = 0;
                if (m[i].wa && m[i].ta == cs) begin m[i].a = cd; m[i].wa = 0; end
                if (m[i].wb && m[i].tb == cs) begin m[i].b = cd; m[i].wb = 0; end
            end
        end
        m_alu_valid = (rd >= 0);
        if (rd >= 0) begin
            m_alu_op   = m[rd].op;
            m_alu_a    = m[rd].a;
            m_alu_b    = m[rd].b;
            m_alu_dest = m[rd].dest;
            m_alu_slot = 2'(rd);
            m[rd].sent = 1;
            exp_q.push_back({m_alu_op, m_alu_a, m_alu_b, m_alu_dest, m_alu_slot});
        end
        if (rs.issue_valid && fs >= 0) begin
            nw.used = 1; nw.sent = 0;
            nw.op = rs.issue_op; nw.dest = rs.issue_dest;
            nw.a = rs.issue_vj; nw.wa = rs.issue_qj[2]; nw.ta = rs.issue_qj[1:0];
            nw.b = rs.issue_vk; nw.wb = rs.issue_qk[2]; nw.tb = rs.issue_qk[1:0];
            if (nw.wa && bc && nw.ta == cs) begin nw.a = cd; nw.wa = 0; end
            if (nw.wb && bc && nw.tb == cs) begin nw.b = cd; nw.wb = 0; end
            m[fs] = nw;
        end
    endtask

    function automatic logic [33:0] model_obs();
        logic [3:0] busy;
        logic       rdy;
        logic [1:0] slot;
        busy = 0; rdy = 0; slot = 0;
        for (int i = 3; i >= 0; i--) begin
            busy[i] = m[i].used;
            if (!m[i].used) begin rdy = 1; slot = 2'(i); end
        end
        return {m_alu_valid, m_alu_op, m_alu_a, m_alu_b, m_alu_dest, m_alu_slot,
                busy, rdy, slot};
    endfunction

    function automatic logic [33:0] dut_obs();
        return {rs.alu_valid, rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot,
                rs.busy_mask, rs.issue_ready, rs.issue_slot};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_idle();
        rs.issue_valid = 0; rs.issue_op = 0; rs.issue_dest = 0;
        rs.issue_vj = 0; rs.issue_vk = 0; rs.issue_qj = 0; rs.issue_qk = 0;
        rs.cdb = CDB_IDLE;
    endtask

    task automatic drive_issue(input logic op, input logic [2:0] dest,
                               input logic [9:0] vj, input logic [9:0] vk,
                               input logic [2:0] qj, input logic [2:0] qk);
        rs.issue_valid = 1; rs.issue_op = op; rs.issue_dest = dest;
        rs.issue_vj = vj; rs.issue_vk = vk; rs.issue_qj = qj; rs.issue_qk = qk;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid, rs.issue_ready, rs.issue_slot} !== 8'b0000_0_1_00) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy/valid/ready/slot %b expected 00000100",
                     {rs.busy_mask, rs.alu_valid, rs.issue_ready, rs.issue_slot});
        end
        n_checks++;
        if ({rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_alu_data: got %h expected 0",
                     {rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot});
        end
        tick();
        n_checks++;
        if ({rs.issue_ready, rs.issue_slot} !== 3'b1_00) begin
            n_fail++;
            $display("FAIL reset_first_cycle: got ready/slot %b expected 100",
                     {rs.issue_ready, rs.issue_slot});
        end
    endtask

    task automatic test_ready_issue();
        do_reset();
        drive_issue(1'b0, 3'b001, 10'd5, 10'd3, 3'b000, 3'b000);
        tick();
        drive_idle();
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid} !== 5'b0001_0) begin
            n_fail++;
            $display("FAIL ready_issue_alloc: got busy/valid %b expected 00010",
                     {rs.busy_mask, rs.alu_valid});
        end
        tick();
        n_checks++;
        if ({rs.alu_valid, rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot} !==
            {1'b1, 1'b0, 10'd5, 10'd3, 3'b001, 2'd0}) begin
            n_fail++;
            $display("FAIL ready_issue_dispatch: got %h expected %h",
                     {rs.alu_valid, rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot},
                     {1'b1, 1'b0, 10'd5, 10'd3, 3'b001, 2'd0});
        end
        rs.cdb = 16'h2405;
        tick();
        drive_idle();
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid} !== 5'b0000_0) begin
            n_fail++;
            $display("FAIL ready_issue_free: got busy/valid %b expected 00000",
                     {rs.busy_mask, rs.alu_valid});
        end
    endtask

    task automatic test_wakeup();
        do_reset();
        drive_issue(1'b1, 3'b010, 10'd0, 10'd7, 3'b101, 3'b000);
        tick();
        drive_idle();
        tick();
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid} !== 5'b0001_0) begin
            n_fail++;
            $display("FAIL wakeup_waiting: got busy/valid %b expected 00010",
                     {rs.busy_mask, rs.alu_valid});
        end
        rs.cdb = {3'b010, 2'b01, 1'b1, 10'd42};
        tick();
        drive_idle();
        n_checks++;
        if (rs.alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wakeup_capture_edge: got alu_valid %b expected 0", rs.alu_valid);
        end
        tick();
        n_checks++;
        if ({rs.alu_valid, rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_slot} !==
            {1'b1, 1'b1, 10'd42, 10'd7, 2'd0}) begin
            n_fail++;
            $display("FAIL wakeup_dispatch: got %h expected %h",
                     {rs.alu_valid, rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_slot},
                     {1'b1, 1'b1, 10'd42, 10'd7, 2'd0});
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive_issue(1'b0, 3'b100, 10'd1, 10'd0, 3'b000, 3'b110);
        rs.cdb = {3'b100, 2'b10, 1'b1, 10'd7};
        tick();
        drive_idle();
        n_checks++;
        if (state_dbg[1:0] !== ST_READY) begin
            n_fail++;
            $display("FAIL forward_no_wait: got state %0d expected %0d", state_dbg[1:0], ST_READY);
        end
        tick();
        n_checks++;
        if ({rs.alu_valid, rs.alu_a, rs.alu_b} !== {1'b1, 10'd1, 10'd7}) begin
            n_fail++;
            $display("FAIL forward_dispatch: got %h expected %h",
                     {rs.alu_valid, rs.alu_a, rs.alu_b}, {1'b1, 10'd1, 10'd7});
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_issue(1'b0, 3'b001, 10'(20 + k), 10'd1, 3'b000, 3'b000);
            tick();
        end
        n_checks++;
        if ({rs.busy_mask, rs.issue_ready} !== 5'b1111_0) begin
            n_fail++;
            $display("FAIL full_not_ready: got busy/ready %b expected 11110",
                     {rs.busy_mask, rs.issue_ready});
        end
        drive_issue(1'b1, 3'b100, 10'd999, 10'd999, 3'b000, 3'b000);
        tick();
        drive_idle();
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid, rs.alu_a, rs.alu_slot} !== {4'b1111, 1'b1, 10'd23, 2'd3}) begin
            n_fail++;
            $display("FAIL full_issue_ignored: got %h expected %h",
                     {rs.busy_mask, rs.alu_valid, rs.alu_a, rs.alu_slot},
                     {4'b1111, 1'b1, 10'd23, 2'd3});
        end
        tick();
        n_checks++;
        if (rs.alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_extra_dispatch: got alu_valid %b expected 0", rs.alu_valid);
        end
        rs.cdb = {3'b001, 2'b10, 1'b1, 10'd0};
        tick();
        drive_idle();
        n_checks++;
        if ({rs.busy_mask, rs.issue_ready, rs.issue_slot} !== {4'b1011, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL full_free_slot: got busy/ready/slot %b expected 1011110",
                     {rs.busy_mask, rs.issue_ready, rs.issue_slot});
        end
    endtask

    task automatic test_ldsd_filter();
        do_reset();
        drive_issue(1'b0, 3'b001, 10'd4, 10'd4, 3'b000, 3'b000);
        tick();
        drive_issue(1'b0, 3'b010, 10'd0, 10'd9, 3'b100, 3'b000);
        tick();
        drive_idle();
        rs.cdb = {3'b001, 2'b00, 1'b0, 10'd99};
        tick();
        drive_idle();
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid} !== 5'b0011_0) begin
            n_fail++;
            $display("FAIL ldsd_no_free: got busy/valid %b expected 00110",
                     {rs.busy_mask, rs.alu_valid});
        end
        tick();
        n_checks++;
        if (rs.alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ldsd_no_capture: got alu_valid %b expected 0", rs.alu_valid);
        end
        rs.cdb = {3'b001, 2'b00, 1'b1, 10'd11};
        tick();
        drive_idle();
        n_checks++;
        if (rs.busy_mask !== 4'b0010) begin
            n_fail++;
            $display("FAIL ldsd_real_free: got busy %b expected 0010", rs.busy_mask);
        end
        tick();
        n_checks++;
        if ({rs.alu_valid, rs.alu_a, rs.alu_b, rs.alu_slot} !== {1'b1, 10'd11, 10'd9, 2'd1}) begin
            n_fail++;
            $display("FAIL ldsd_real_capture: got %h expected %h",
                     {rs.alu_valid, rs.alu_a, rs.alu_b, rs.alu_slot},
                     {1'b1, 10'd11, 10'd9, 2'd1});
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_issue(1'b1, 3'b100, 10'(100 + k), 10'd2, 3'b000, 3'b000);
            tick();
        end
        drive_idle();
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid} !== 5'b0111_1) begin
            n_fail++;
            $display("FAIL midop_setup: got busy/valid %b expected 01111",
                     {rs.busy_mask, rs.alu_valid});
        end
        #2;
        reset = 0;
        #1;
        n_checks++;
        if ({rs.busy_mask, rs.alu_valid, rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot} !== 31'd0) begin
            n_fail++;
            $display("FAIL midop_async_clear: got %h expected 0",
                     {rs.busy_mask, rs.alu_valid, rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot});
        end
        model_reset();
        @(negedge clock);
        reset = 1;
        tick();
        n_checks++;
        if ({rs.issue_ready, rs.issue_slot, rs.busy_mask} !== 7'b1_00_0000) begin
            n_fail++;
            $display("FAIL midop_after_release: got ready/slot/busy %b expected 1000000",
                     {rs.issue_ready, rs.issue_slot, rs.busy_mask});
        end
    endtask

    task automatic test_random();
        logic [25:0] item;
        logic [2:0]  d;
        int          sel;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            drive_idle();
            if ($urandom_range(0, 9) < 7) begin
                d = 3'(1 << $urandom_range(0, 2));
                drive_issue(1'($urandom_range(0, 1)), d,
                            10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                            ($urandom_range(0, 1) != 0) ? {1'b1, 2'($urandom_range(0, 3))} : 3'b000,
                            ($urandom_range(0, 2) == 0) ? {1'b1, 2'($urandom_range(0, 3))} : 3'b000);
            end
            sel = $urandom_range(0, 99);
            d   = 3'(1 << $urandom_range(0, 2));
            if (sel < 40)
                rs.cdb = {d, 2'($urandom_range(0, 3)), 1'b1, 10'($urandom_range(0, 1023))};
            else if (sel < 55)
                rs.cdb = {d, 2'($urandom_range(0, 3)), 1'b0, 10'($urandom_range(0, 1023))};
            else if (sel < 60)
                rs.cdb = {3'b000, 2'($urandom_range(0, 3)), 1'b1, 10'($urandom_range(0, 1023))};
            tick();
            n_checks++;
            if (dut_obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL random_outputs cycle %0d: got %h expected %h", c, dut_obs(), model_obs());
            end
            n_checks++;
            if (rs.alu_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_unexpected_dispatch cycle %0d: got slot %0d expected none",
                             c, rs.alu_slot);
                end else begin
                    item = exp_q.pop_front();
                    if ({rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot} !== item) begin
                        n_fail++;
                        $display("FAIL random_dispatch cycle %0d: got %h expected %h", c,
                                 {rs.alu_op, rs.alu_a, rs.alu_b, rs.alu_dest, rs.alu_slot}, item);
                    end
                end
            end else if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL random_missing_dispatch cycle %0d: got none expected %h", c, exp_q[0]);
                exp_q.delete();
            end
        end
        drive_idle();
    endtask

    initial begin
        model_reset();
        drive_idle();
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_forwarding();
        test_full();
        test_ldsd_filter();
        test_midop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
